// File: rtl/proc_pkg.sv
// Shared constants for the simple-processor control path: opcodes, time-step
// encoding, bus-select bit positions and the instruction field layout.
package proc_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int REG_W    = 3;
  localparam int IR_W     = 9;
  localparam int SEL_W    = NUM_REGS + 2;

  localparam int SEL_G    = 8;
  localparam int SEL_DIN  = 9;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  // III XXX YYY, opcode in the top three bits.
  typedef struct packed {
    logic [2:0]       op;
    logic [REG_W-1:0] rx;
    logic [REG_W-1:0] ry;
  } instr_t;

  function automatic logic is_alu(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/dec3to8.sv
// Register-index decoder: 3-bit index to 8-bit one-hot, all-zero when disabled.
module dec3to8
  import proc_pkg::*;
(
  input  logic                en,
  input  logic [REG_W-1:0]    idx,
  output logic [NUM_REGS-1:0] onehot
);

  // NOTE: the default assignment before the conditional write keeps this
  // block purely combinational; without it a latch would be inferred.
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/processor_control_fsm.sv
// Control sequencer for the 16-bit simple processor: latches an instruction in
// T0 and steps it through T1..T3, decoding bus-source and load strobes.
module processor_control_fsm
  import proc_pkg::*;
(
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                Run,
  input  logic [DATA_W-1:0]   DIN,
  input  logic                G_nz,
  output logic [SEL_W-1:0]    BusSel,
  output logic [NUM_REGS-1:0] Rin,
  output logic                Ain,
  output logic                Gin,
  output logic                AddSub,
  output logic                Done
);

  logic [1:0]          tstep;
  logic [1:0]          tstep_next;
  instr_t              ir;
  logic [NUM_REGS-1:0] x_sel;
  logic [NUM_REGS-1:0] y_sel;
  logic                active;

  // Only the low IR_W bits of DIN carry the instruction; the rest is data.
  logic unused_din;
  assign unused_din = &{1'b0, DIN[DATA_W-1:IR_W]};

  assign active = (tstep != T0);

  dec3to8 u_dec_x (.en(active), .idx(ir.rx), .onehot(x_sel));
  dec3to8 u_dec_y (.en(active), .idx(ir.ry), .onehot(y_sel));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      tstep <= T0;
      ir    <= '0;
    end else begin
      tstep <= tstep_next;
      if (tstep == T0 && Run) ir <= instr_t'(DIN[IR_W-1:0]);
    end
  end

  always_comb begin
    tstep_next = T0;
    case (tstep)
      T0: tstep_next = Run ? T1 : T0;
      T1: tstep_next = is_alu(ir.op) ? T2 : T0;
      T2: tstep_next = T3;
      default: tstep_next = T0;
    endcase
  end

  // Outputs are a pure decode of the step and IR, so an async reset to T0
  // silences every strobe in the same instant.
  always_comb begin
    BusSel = '0;
    Rin    = '0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    AddSub = 1'b0;
    Done   = 1'b0;
    case (tstep)
      T1: begin
        case (ir.op)
          OP_MV: begin
            BusSel[NUM_REGS-1:0] = y_sel;
            Rin                  = x_sel;
            Done                 = 1'b1;
          end
          OP_MVI: begin
            BusSel[SEL_DIN] = 1'b1;
            Rin             = x_sel;
            Done            = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            BusSel[NUM_REGS-1:0] = x_sel;
            Ain                  = 1'b1;
          end
          OP_MVNZ: begin
            if (G_nz) begin
              BusSel[NUM_REGS-1:0] = y_sel;
              Rin                  = x_sel;
            end
            Done = 1'b1;
          end
          default: Done = 1'b1;
        endcase
      end
      T2: begin
        BusSel[NUM_REGS-1:0] = y_sel;
        Gin                  = 1'b1;
        AddSub               = (ir.op == OP_SUB);
      end
      T3: begin
        BusSel[SEL_G] = 1'b1;
        Rin           = x_sel;
        Done          = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_processor_control_fsm.sv
// Scoreboard bench for processor_control_fsm: stimulus queues the expected
// strobe frames with their cycle stamps, a negedge monitor pops and compares.
module tb_processor_control_fsm;
  import proc_pkg::*;

  logic                Clock = 1'b0;
  logic                Resetn;
  logic                Run;
  logic [DATA_W-1:0]   DIN;
  logic                G_nz;
  logic [SEL_W-1:0]    BusSel;
  logic [NUM_REGS-1:0] Rin;
  logic                Ain, Gin, AddSub, Done;

  typedef struct {
    logic [SEL_W-1:0]    bussel;
    logic [NUM_REGS-1:0] rin;
    logic                ain, gin, addsub, done;
    int                  cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  processor_control_fsm dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .DIN(DIN), .G_nz(G_nz),
    .BusSel(BusSel), .Rin(Rin), .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .Done(Done)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] pack_out();
    return 32'({BusSel, Rin, Ain, Gin, AddSub, Done});
  endfunction

  // Expected frame k cycles after the T1 of an instruction issued now.
  task automatic expect_frame(input logic [9:0] bs, input logic [7:0] ri,
                              input logic a, input logic g, input logic s,
                              input logic d, input int k);
    sb.push_back('{bussel: bs, rin: ri, ain: a, gin: g, addsub: s, done: d,
                   cyc: cyc + 1 + k});
  endtask

  // Issue one instruction from T0, then wait until the FSM is back in T0.
  task automatic go(input logic [8:0] ir, input logic gnz, input int steps);
    Run = 1'b1;
    DIN = {7'd0, ir};
    @(posedge Clock); #1;
    Run  = 1'b0;
    DIN  = 16'h0005;
    G_nz = gnz;
    repeat (steps) begin
      @(posedge Clock); #1;
    end
    G_nz = 1'b0;
  endtask

  // Monitor: any nonzero output is a frame that must match the queue head.
  always @(negedge Clock) begin
    if (Resetn === 1'b1) begin
      if (BusSel != 0 || Rin != 0 || Ain || Gin || AddSub || Done) begin
        logic ok;
        if (Rin != 0 || Ain || Gin) ok = $onehot(BusSel);
        else                        ok = (BusSel == 0);
        ok = ok && $onehot0(Rin);
        check("onehot_invariant", 32'(ok), 32'd1);
        if (sb.size() == 0) begin
          check("unexpected_frame", pack_out(), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("frame", pack_out(),
                32'({e.bussel, e.rin, e.ain, e.gin, e.addsub, e.done}));
          check("frame_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    Resetn = 1'b0;
    Run    = 1'b1;
    DIN    = 16'h0040;
    G_nz   = 1'b0;
    #1 check("reset_outputs_t0", pack_out(), 32'd0);
    repeat (2) @(posedge Clock);
    #1 check("reset_outputs_held", pack_out(), 32'd0);
    Run    = 1'b0;
    Resetn = 1'b1;
    @(posedge Clock); #1;

    // 1. mvi R0
    expect_frame(10'h200, 8'h01, 0, 0, 0, 1, 0);
    go(9'b001_000_000, 1'b0, 1);
    // 2. mv R3,R0
    expect_frame(10'h001, 8'h08, 0, 0, 0, 1, 0);
    go(9'b000_011_000, 1'b0, 1);
    // 3. add R3,R1
    expect_frame(10'h008, 8'h00, 1, 0, 0, 0, 0);
    expect_frame(10'h002, 8'h00, 0, 1, 0, 0, 1);
    expect_frame(10'h100, 8'h08, 0, 0, 0, 1, 2);
    go(9'b010_011_001, 1'b0, 3);
    // 4. sub R1,R1
    expect_frame(10'h002, 8'h00, 1, 0, 0, 0, 0);
    expect_frame(10'h002, 8'h00, 0, 1, 1, 0, 1);
    expect_frame(10'h100, 8'h02, 0, 0, 0, 1, 2);
    go(9'b011_001_001, 1'b0, 3);
    // 5. mvnz R2,R1 with G_nz low, then high
    expect_frame(10'h000, 8'h00, 0, 0, 0, 1, 0);
    go(9'b100_010_001, 1'b0, 1);
    expect_frame(10'h002, 8'h04, 0, 0, 0, 1, 0);
    go(9'b100_010_001, 1'b1, 1);
    // Register index extremes
    expect_frame(10'h200, 8'h80, 0, 0, 0, 1, 0);
    go(9'b001_111_000, 1'b0, 1);
    expect_frame(10'h080, 8'h01, 0, 0, 0, 1, 0);
    go(9'b000_000_111, 1'b0, 1);
    expect_frame(10'h080, 8'h00, 1, 0, 0, 0, 0);
    expect_frame(10'h080, 8'h00, 0, 1, 0, 0, 1);
    expect_frame(10'h100, 8'h80, 0, 0, 0, 1, 2);
    go(9'b010_111_111, 1'b0, 3);
    // Illegal opcodes behave as nops that still complete
    expect_frame(10'h000, 8'h00, 0, 0, 0, 1, 0);
    go(9'b111_010_011, 1'b1, 1);
    expect_frame(10'h000, 8'h00, 0, 0, 0, 1, 0);
    go(9'b101_110_001, 1'b0, 1);

    // 6. add R5,R6 abandoned by reset during T2: no T3 frame may follow
    expect_frame(10'h020, 8'h00, 1, 0, 0, 0, 0);
    expect_frame(10'h040, 8'h00, 0, 1, 0, 0, 1);
    Run = 1'b1;
    DIN = 16'h00AE;
    @(posedge Clock); #1;
    Run = 1'b0;
    @(posedge Clock);
    @(negedge Clock); #1;
    Resetn = 1'b0;
    #1 check("reset_mid_add", pack_out(), 32'd0);
    @(posedge Clock); #1;
    check("reset_mid_add_held", pack_out(), 32'd0);
    Resetn = 1'b1;
    repeat (3) begin
      @(posedge Clock); #1;
    end

    // Back-to-back: Run held across Done fetches mv then mvi with one T0 between
    expect_frame(10'h001, 8'h02, 0, 0, 0, 1, 0);
    expect_frame(10'h200, 8'h20, 0, 0, 0, 1, 2);
    Run = 1'b1;
    DIN = 16'h0008;
    @(posedge Clock); #1;
    DIN = 16'h0068;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Run = 1'b0;
    DIN = 16'h1234;
    @(posedge Clock); #1;

    repeat (4) begin
      @(posedge Clock); #1;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
